// File: rtl/risc16_pkg.sv
// Shared RiSC-16 constants and the writeback entry type used by the
// writeback queue and its consumers.
package risc16_pkg;

  localparam int WORD_LEN     = 16;
  localparam int REG_ADDR_LEN = 3;
  localparam int REG_COUNT    = 8;

  typedef struct packed {
    logic [REG_ADDR_LEN-1:0] tgt;
    logic [WORD_LEN-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-first lookup of a register address across the queued writeback
// entries; returns whether any valid entry targets it and that entry's data.
module wbq_match #(
  parameter int p_WORD_LEN     = 16,
  parameter int p_REG_ADDR_LEN = 3,
  parameter int p_DEPTH        = 4
) (
  input  logic [p_DEPTH-1:0][p_REG_ADDR_LEN-1:0] i_tgts,
  input  logic [p_DEPTH-1:0][p_WORD_LEN-1:0]     i_data,
  input  logic [p_DEPTH-1:0]                     i_valid,
  input  logic [$clog2(p_DEPTH)-1:0]             i_wr_ptr,
  input  logic [p_REG_ADDR_LEN-1:0]              i_addr,
  output logic                                   o_hit,
  output logic [p_WORD_LEN-1:0]                  o_data
);

  localparam int PTR_W = $clog2(p_DEPTH);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so a younger match overwrites an older one;
  // k == p_DEPTH truncates to the write pointer itself (oldest when full).
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = p_DEPTH; k >= 1; k--) begin
      w_idx = i_wr_ptr - PTR_W'(k);
      if (i_valid[w_idx] && (i_tgts[w_idx] == i_addr) && (i_addr != '0)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Writeback FIFO feeding the register file write port, one commit per cycle.
// Define WBQ_BYPASS_EN to build the operand bypass lookups.
module reg_wb_queue
  import risc16_pkg::*;
#(
  parameter int p_WORD_LEN     = WORD_LEN,
  parameter int p_REG_ADDR_LEN = REG_ADDR_LEN,
  parameter int p_DEPTH        = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [p_REG_ADDR_LEN-1:0]   i_tgt,
  input  logic [p_WORD_LEN-1:0]       i_tgt_data,
  input  logic                        i_hold,
  output logic [p_REG_ADDR_LEN-1:0]   o_tgt,
  output logic [p_WORD_LEN-1:0]       o_tgt_data,
  output logic                        o_wr_en,
  input  logic [p_REG_ADDR_LEN-1:0]   i_src1,
  input  logic [p_REG_ADDR_LEN-1:0]   i_src2,
  output logic                        o_src1_hit,
  output logic [p_WORD_LEN-1:0]       o_src1_data,
  output logic                        o_src2_hit,
  output logic [p_WORD_LEN-1:0]       o_src2_data,
  output logic [$clog2(p_DEPTH):0]    o_count,
  output logic                        o_empty,
  output logic                        o_full
);

  localparam int PTR_W = $clog2(p_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [p_DEPTH-1:0][p_REG_ADDR_LEN-1:0] r_tgt;
  logic [p_DEPTH-1:0][p_WORD_LEN-1:0]     r_data;
  logic [PTR_W-1:0]                       r_wr_ptr;
  logic [PTR_W-1:0]                       r_rd_ptr;
  logic [CNT_W-1:0]                       r_count;

  logic             w_push;
  logic             w_store;
  logic             w_pop;
  logic [PTR_W-1:0] w_offset;
  logic [p_DEPTH-1:0] w_valid;

  // Handshake: an entry transfers on the rising edge where i_valid and
  // o_ready are both high; o_ready depends only on registered occupancy.
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(p_DEPTH));
  assign o_ready = !o_full;
  assign o_count = r_count;

  assign w_push  = i_valid & o_ready;
  assign w_store = w_push & (i_tgt != '0);
  assign o_wr_en = !o_empty & !i_hold;
  assign w_pop   = o_wr_en;

  assign o_tgt      = o_wr_en ? r_tgt[r_rd_ptr]  : '0;
  assign o_tgt_data = o_wr_en ? r_data[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_store) begin
      r_tgt[r_wr_ptr]  <= i_tgt;
      r_data[r_wr_ptr] <= i_tgt_data;
    end
  end

  always_comb begin
    w_offset = '0;
    w_valid  = '0;
    for (int i = 0; i < p_DEPTH; i++) begin
      w_offset   = PTR_W'(i) - r_rd_ptr;
      w_valid[i] = ({1'b0, w_offset} < r_count);
    end
  end

`ifdef WBQ_BYPASS_EN
  wbq_match #(
    .p_WORD_LEN(p_WORD_LEN), .p_REG_ADDR_LEN(p_REG_ADDR_LEN), .p_DEPTH(p_DEPTH)
  ) u_match1 (
    .i_tgts(r_tgt), .i_data(r_data), .i_valid(w_valid), .i_wr_ptr(r_wr_ptr),
    .i_addr(i_src1), .o_hit(o_src1_hit), .o_data(o_src1_data)
  );

  wbq_match #(
    .p_WORD_LEN(p_WORD_LEN), .p_REG_ADDR_LEN(p_REG_ADDR_LEN), .p_DEPTH(p_DEPTH)
  ) u_match2 (
    .i_tgts(r_tgt), .i_data(r_data), .i_valid(w_valid), .i_wr_ptr(r_wr_ptr),
    .i_addr(i_src2), .o_hit(o_src2_hit), .o_data(o_src2_data)
  );
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_src1, i_src2, w_valid};
  assign o_src1_hit  = 1'b0;
  assign o_src1_data = '0;
  assign o_src2_hit  = 1'b0;
  assign o_src2_data = '0;
`endif

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
Writeback queue that initiates writes into the RiSC-16 register file. It buffers {target, data} results from the execute/memory stages in a small FIFO and drains one entry per cycle onto the register file write port. It optionally provides a youngest-match bypass so operand reads see queued, not-yet-committed results. It sits between the result producers and the register file.

Parameters:
p_WORD_LEN, 16, data word width
p_REG_ADDR_LEN, 3, register address width
p_DEPTH, 4, queue entries; power of 2, minimum 2

Ports:
i_clk  input  1  clock; all state updates on posedge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  producer offers an entry this cycle
o_ready  output  1  queue can accept; equals !o_full
i_tgt  input  p_REG_ADDR_LEN  target register of offered entry
i_tgt_data  input  p_WORD_LEN  data of offered entry
i_hold  input  1  high suppresses draining this cycle
o_tgt  output  p_REG_ADDR_LEN  write address to register file
o_tgt_data  output  p_WORD_LEN  write data to register file
o_wr_en  output  1  write strobe to register file
i_src1  input  p_REG_ADDR_LEN  bypass lookup address 1
i_src2  input  p_REG_ADDR_LEN  bypass lookup address 2
o_src1_hit  output  1  queued entry matches i_src1
o_src1_data  output  p_WORD_LEN  data of youngest match for i_src1
o_src2_hit  output  1  queued entry matches i_src2
o_src2_data  output  p_WORD_LEN  data of youngest match for i_src2
o_count  output  clog2(p_DEPTH)+1  occupied entries
o_empty  output  1  o_count==0
o_full  output  1  o_count==p_DEPTH

Behaviour:
- Clock is i_clk. Reset is synchronous and active-high on i_rst.
- Reset: read/write pointers and count are 0, so o_empty=1, o_full=0, o_ready=1, o_wr_en=0, o_tgt=0, o_tgt_data=0, all hits 0, all bypass data 0.
- Reset mid-operation discards all queued entries. A push or pop in the reset cycle has no effect.
- Push: occurs at posedge when i_valid & o_ready & !i_rst. The entry is stored at the write pointer, which then increments mod p_DEPTH.
- Push with i_tgt==0: the handshake completes but the entry is not stored and count is unchanged.
- When full, o_ready=0 even if a pop happens the same cycle; there is no push-through-when-full.
- Drain: o_wr_en = !o_empty & !i_hold, combinational. When o_wr_en=1, o_tgt/o_tgt_data present the head entry. When o_wr_en=0, o_tgt and o_tgt_data are forced to 0.
- The head pops at the posedge where o_wr_en=1, the same edge on which the register file commits the write.
- Latency: no cut-through. An entry pushed at edge N into an empty queue commits at edge N+1 at the earliest.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Count and pointers: pointers are clog2(p_DEPTH) bits and wrap naturally. o_count is tracked separately and never exceeds p_DEPTH or underflows.
- Bypass (combinational): o_srcN_hit=1 iff a valid entry has tgt==i_srcN and i_srcN!=0. o_srcN_data is the data of the youngest such entry (closest to the write pointer); it is 0 on a miss.
- The entry at the head being written this cycle still counts as a hit.
- The entry being offered on i_valid this cycle is not visible to bypass.
- Order: entries commit strictly in push order. Multiple entries for the same target are all written, oldest first.

Optional Feature:
WBQ_BYPASS_EN
- Defined: bypass match logic is present as described above.
- Undefined: the match logic is removed; o_src1_hit, o_src2_hit, o_src1_data and o_src2_data are constant 0. The ports remain in the interface.

Decomposition:
- Shared package risc16_pkg holds:
  - word/address width constants (16, 3)
  - register file size 8
  - wb_entry_t typedef = {tgt, data}
- Sub-module wbq_match: given the entry array, a valid mask, the write pointer and a lookup address, returns {hit, data} via a youngest-first priority search. It is instantiated twice.

Test Plan:
- Reset, then push {tgt=3, data=16'h1234} into an empty queue -> o_wr_en=1 the next cycle with o_tgt=3 and o_tgt_data=16'h1234; o_empty=1 after that edge.
- Push 4 entries (r1..r4, data 1..4) with i_hold=1 -> o_full=1, o_ready=0, and a 5th push is ignored. Release i_hold -> writes r1..r4 in order over 4 cycles, then o_empty=1.
- Push {tgt=0, data=16'hFFFF} -> handshake completes, o_count stays 0, o_wr_en never asserts.
- i_hold=1; push r5=16'hAAAA then r5=16'hBBBB; i_src1=5 -> o_src1_hit=1, o_src1_data=16'hBBBB. With i_src2=0 -> o_src2_hit=0. Without WBQ_BYPASS_EN -> hit=0, data=0.
- Queue holds 2 entries; push and pop in the same cycle -> o_count stays 2, and the pointers wrap correctly across 3*p_DEPTH operations.
- Queue holds 3 entries; assert i_rst for one cycle while i_valid=1 -> o_count=0, o_wr_en=0 the next cycle, and no entry is written afterwards.
